// File: rtl/ssd_display_arbiter.sv
// Round-robin time-slicing of a four-digit seven-segment display
// among four requesting sources with a fixed dwell per slot.
module ssd_display_arbiter #(
  parameter int DWELL_COUNTS = 200_000_000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [127:0] words,
  output logic [31:0]  word,
  output logic         enable,
  output logic [3:0]   grant,
  output logic [1:0]   owner,
  output logic         slot_start
);

  localparam int CW = $clog2(DWELL_COUNTS);
  localparam logic [CW-1:0] RELOAD = CW'(DWELL_COUNTS - 1);

  typedef enum logic {
    IDLE,
    HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    owner_q, owner_d;
  logic [3:0]    grant_q, grant_d;
  logic [31:0]   word_q, word_d;
  logic          en_q, en_d;
  logic          ss_q, ss_d;

  logic [3:0]    own_oh;
  logic [3:0]    others;
  logic [2:0]    pick_all;
  logic [2:0]    pick_oth;

  // {found, index}: first set mask bit in order last+1 .. last+4 (mod 4)
  function automatic logic [2:0] rr_pick(
    input logic [1:0] last,
    input logic [3:0] mask
  );
    logic [1:0] cand;
    logic [1:0] pick;
    logic       found;
    pick  = last;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && mask[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    return {found, pick};
  endfunction

  assign own_oh   = 4'b0001 << owner_q;
  assign others   = req & ~own_oh;
  assign pick_all = rr_pick(owner_q, req);
  assign pick_oth = rr_pick(owner_q, others);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    ss_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_all[2]) begin
          state_d = HOLD;
          owner_d = pick_all[1:0];
          cnt_d   = RELOAD;
          ss_d    = 1'b1;
        end
      end
      HOLD: begin
        // release outranks expiry when both land on the same cycle
        if (!req[owner_q]) begin
          if (pick_oth[2]) begin
            owner_d = pick_oth[1:0];
            cnt_d   = RELOAD;
            ss_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q == '0) begin
          cnt_d = RELOAD;
          if (pick_oth[2]) begin
            owner_d = pick_oth[1:0];
            ss_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs follow the next owner so text and grant switch together
  always_comb begin
    grant_d = 4'b0000;
    en_d    = 1'b0;
    word_d  = 32'h0;
    if (state_d == HOLD) begin
      grant_d = 4'b0001 << owner_d;
      en_d    = 1'b1;
      word_d  = words[{owner_d, 5'b00000} +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      owner_q <= 2'd3;
      grant_q <= 4'b0000;
      word_q  <= 32'h0;
      en_q    <= 1'b0;
      ss_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      word_q  <= word_d;
      en_q    <= en_d;
      ss_q    <= ss_d;
    end
  end

  assign word       = word_q;
  assign enable     = en_q;
  assign grant      = grant_q;
  assign owner      = owner_q;
  assign slot_start = ss_q;

endmodule

// File: tb/tb_ssd_display_arbiter.sv
// Scoreboard bench for ssd_display_arbiter: directed cycles push
// expected outputs, a negedge monitor pops and compares.
module tb_ssd_display_arbiter;

  logic         clk;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] words;
  logic [31:0]  word;
  logic         enable;
  logic [3:0]   grant;
  logic [1:0]   owner;
  logic         slot_start;

  logic [31:0]  src_w [4];

  typedef struct {
    logic [3:0]  g;
    logic [1:0]  o;
    logic        en;
    logic [31:0] w;
    logic        ss;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_vec;
  int   n_err;

  ssd_display_arbiter #(.DWELL_COUNTS(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .words      (words),
    .word       (word),
    .enable     (enable),
    .grant      (grant),
    .owner      (owner),
    .slot_start (slot_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb words = {src_w[3], src_w[2], src_w[1], src_w[0]};

  // one clock: drive inputs, take the edge, record expected outputs
  task automatic cyc(
    input logic        rst,
    input logic [3:0]  r,
    input logic [3:0]  eg,
    input logic [1:0]  eo,
    input logic [31:0] ew,
    input logic        es,
    input string       tag
  );
    exp_t e;
    reset = rst;
    req   = r;
    @(posedge clk);
    #1;
    e.g   = eg;
    e.o   = eo;
    e.en  = (eg != 4'b0000);
    e.w   = ew;
    e.ss  = es;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic hold(
    input logic [3:0] r,
    input logic [1:0] o,
    input int         n,
    input logic       first_ss,
    input string      tag
  );
    for (int i = 0; i < n; i++)
      cyc(1'b0, r, 4'b0001 << o, o, src_w[o], first_ss && i == 0, tag);
  endtask

  task automatic rst_cyc(input logic [3:0] r, input string tag);
    cyc(1'b1, r, 4'b0000, 2'd3, 32'h0, 1'b0, tag);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_vec++;
        if (grant !== e.g || owner !== e.o || enable !== e.en ||
            word !== e.w || slot_start !== e.ss) begin
          n_err++;
          $display("FAIL %s: got g=%b o=%0d en=%b w=%h ss=%b want g=%b o=%0d en=%b w=%h ss=%b",
                   e.tag, grant, owner, enable, word, slot_start,
                   e.g, e.o, e.en, e.w, e.ss);
        end
      end
    end
  end

  initial begin : stim
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    req      = 4'b0000;
    src_w[0] = 32'h53595330;
    src_w[1] = 32'h45525231;
    src_w[2] = 32'h48454C50;
    src_w[3] = 32'h44424733;

    for (int i = 0; i < 3; i++) rst_cyc(4'b1111, "reset");

    cyc(1'b0, 4'b0100, 4'b0100, 2'd2, 32'h48454C50, 1'b1, "single_grant");
    hold(4'b0100, 2'd2, 19, 1'b0, "single_hold");
    src_w[2] = 32'h00000041;
    cyc(1'b0, 4'b0100, 4'b0100, 2'd2, 32'h00000041, 1'b0, "word_follow");
    hold(4'b0100, 2'd2, 3, 1'b0, "word_hold");

    rst_cyc(4'b1111, "rot_reset");
    hold(4'b1111, 2'd0, 8, 1'b1, "rot_s0");
    hold(4'b1111, 2'd1, 8, 1'b1, "rot_s1");
    hold(4'b1111, 2'd2, 8, 1'b1, "rot_s2");
    hold(4'b1111, 2'd3, 8, 1'b1, "rot_s3");
    hold(4'b1111, 2'd0, 8, 1'b1, "rot_s0b");

    rst_cyc(4'b1010, "early_reset");
    hold(4'b1010, 2'd1, 3, 1'b1, "early_own1");
    hold(4'b1000, 2'd3, 1, 1'b1, "early_hand");
    hold(4'b1001, 2'd3, 7, 1'b0, "early_own3");
    hold(4'b1001, 2'd0, 1, 1'b1, "early_next");

    rst_cyc(4'b0100, "idle_reset");
    hold(4'b0100, 2'd2, 8, 1'b1, "idle_own2");
    cyc(1'b0, 4'b0000, 4'b0000, 2'd2, 32'h0, 1'b0, "drop_expire");
    cyc(1'b0, 4'b0000, 4'b0000, 2'd2, 32'h0, 1'b0, "idle_stay");
    hold(4'b0001, 2'd0, 2, 1'b1, "rereq_src0");

    rst_cyc(4'b0100, "mid_reset0");
    hold(4'b0100, 2'd2, 5, 1'b1, "mid_own2");
    rst_cyc(4'b0110, "mid_reset");
    hold(4'b0110, 2'd1, 3, 1'b1, "after_rst");

    begin : drain
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
        @(negedge clk);
        budget++;
      end
      #1;
      if (sb.size() > 0) begin
        n_err++;
        $display("FAIL drain: got %0d pending want 0", sb.size());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ssd_display_arbiter.md
# ssd_display_arbiter

Time-slices the four-digit seven-segment display between up to four requesting sources: system status, error codes, user readout, debug. Each source presents a 32-bit word (four 8-bit character codes, MSB byte = leftmost digit) plus a request line. The block grants the display round-robin with a fixed dwell time per slot. It drives the `word`/`enable` inputs of the SSD controller directly.

## Interface
- `DWELL_COUNTS`, default 200_000_000: clk cycles per display slot (2 s at 100 MHz); must be ≥ 2.
- `clk`  input  1  system clock (100 MHz).
- `reset`  input  1  synchronous, active-high reset.
- `req`  input  4  request per source; bit i = source i wants the display.
- `words`  input  128  packed source words; source i = `words[32*i+31 : 32*i]`.
- `word`  output  32  registered word to SSD controller.
- `enable`  output  1  registered display enable to SSD controller.
- `grant`  output  4  registered one-hot current owner; 0 when idle.
- `owner`  output  2  registered index of current owner; holds last value when idle.
- `slot_start`  output  1  one-cycle pulse on every change of owner, including idle→owned.

## Operation
- Clocked on `clk`; reset is synchronous and active-high. Everything updates on the rising edge.
- State machine has two states, IDLE and HOLD.
- Reset values: state IDLE, `grant`=0, `owner`=3 (so the first search starts at source 0), `enable`=0, `word`=0, `slot_start`=0, dwell counter=0.
- Round-robin search order from last owner L: L+1, L+2, L+3, L (mod 4). The first set `req` bit in that order wins.
- IDLE:
  - `enable`=0, `word`=0, `grant`=0.
  - If any `req` bit is set: grant the winner, load counter with DWELL_COUNTS-1, go to HOLD, pulse `slot_start`.
- HOLD, evaluated each cycle with owner O:
  - **Owner drops `req`, other requests pending:** hand over next edge to the search winner, excluding O. Reload counter, pulse `slot_start`.
  - **Owner drops `req`, no other requests:** go to IDLE next edge. `enable`=0, `word`=0, `grant`=0. `owner` retains O.
  - **Counter = 0, others requesting:** hand over to the search winner. O is last in the order, so another source always wins. Reload counter, pulse `slot_start`.
  - **Counter = 0, only O requesting:** O keeps the display. Reload counter, no `slot_start`.
  - **Otherwise:** decrement counter.
- Owner-drop check takes priority over the expiry check when both occur in the same cycle.
- While in HOLD, `word` is reloaded every cycle from the owner's slice of `words`. Sources may update their text live.
- On handover, `word` is loaded from the new owner's slice on the same edge that `grant` changes. The outgoing owner's text is never shown under the new grant.
- `enable`=1 exactly when `grant`≠0.
- Counter width is $clog2(DWELL_COUNTS). The counter never wraps: reload occurs at 0.
- `req` bits that rise and fall while another source holds the display are not latched. A source must hold `req` until granted.

## Timing
- Request-to-grant latency:
  - From IDLE: `req` high before edge N gives `grant`/`word`/`enable` valid after edge N (1 cycle).
- Dwell: a grant taken at edge E persists through edge E+DWELL_COUNTS-1. Handover occurs at edge E+DWELL_COUNTS when contended.
- Owner release: `req` deasserted before edge N causes the handover or idle transition at edge N.
- Word latency: a change on the owner's `words` slice before edge N appears on `word` after edge N.
- `slot_start` is high for exactly the cycle following the edge at which the owner changed.
- Reset asserted in any state returns all outputs to reset values at the next edge. No grant is issued during reset, even with `req` high. The first grant follows the first edge after reset deasserts, searching from source 0.

## Test plan
Bench uses DWELL_COUNTS=8.
- **Reset values:** `reset`=1 for 3 cycles with `req`=4'b1111 → `grant`=0, `enable`=0, `word`=0, `owner`=3, `slot_start`=0 throughout.
- **Single requester:** `req`=4'b0100, `words` slice 2 = 32'h48454C50 → one cycle later `grant`=4'b0100, `owner`=2, `enable`=1, `word`=32'h48454C50, one `slot_start` pulse. Grant is held indefinitely with no further pulses. Change slice 2 to 32'h00000041 → `word` follows 1 cycle later.
- **Rotation:** after reset, `req`=4'b1111 → grants 0,1,2,3,0 with each grant lasting exactly 8 cycles and `slot_start` pulsing at each change.
- **Early release:** owner 1 drops `req` 3 cycles into its slot while `req[3]`=1 → next edge `grant`=4'b1000, counter reloaded, new slot lasts 8 cycles.
- **Release to idle and simultaneous events:** sole owner drops `req` on the same cycle its counter hits 0 → IDLE next edge: `enable`=0, `word`=0, no `slot_start`. Re-request from source 0 while `owner`=2 → `grant`=4'b0001.
- **Reset mid-slot:** assert `reset` for 1 cycle during owner 2's 5th cycle → all outputs return to reset values. After release with `req`=4'b0110, first grant goes to source 1.
